// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// Divides a DW-bit unsigned dividend by a VW-bit unsigned divisor and
// returns a DW-bit quotient and a VW-bit remainder. The start/busy/done
// handshake accepts a new request in IDLE or in the FIN (done) cycle.
// A zero divisor completes in one cycle with quotient all-ones and dbz set.
// Optional macro SEQ_DIVIDER_SELF_CHECK_EN adds a reconstruction check
// (quotient*divisor + remainder == dividend, remainder < divisor) that sets
// the sticky chk_err output; without it chk_err is tied low.
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz,
    output logic          chk_err
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] shift_reg;
    logic [VW-1:0] divisor_reg;
    logic [VW:0]   prem_reg;
    logic [CW-1:0] count_reg;

    logic          accept;
    logic [VW+1:0] prem_shift;
    logic [VW:0]   trial;
    logic          trial_ok;
    logic [VW:0]   prem_next;
    logic [DW-1:0] shift_next;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    // The compare uses the full shifted width so the subtract only needs VW+1 bits.
    always_comb begin
        accept     = start && (state_reg != RUN);
        prem_shift = {prem_reg, shift_reg[DW-1]};
        trial      = prem_shift[VW:0] - {1'b0, divisor_reg};
        trial_ok   = (prem_shift >= {2'b00, divisor_reg});
        prem_next  = trial_ok ? trial : prem_shift[VW:0];
        shift_next = {shift_reg[DW-2:0], trial_ok};
    end

    // Control FSM and datapath; results are registered on the edge entering FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            divisor_reg <= '0;
            prem_reg    <= '0;
            count_reg   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            dbz         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE, FIN: begin
                    if (accept) begin
                        if (divisor != '0) begin
                            shift_reg   <= dividend;
                            divisor_reg <= divisor;
                            prem_reg    <= '0;
                            count_reg   <= '0;
                            busy        <= 1'b1;
                            state_reg   <= RUN;
                        end else begin
                            // Divide by zero finishes immediately without entering RUN.
                            quotient  <= '1;
                            remainder <= '0;
                            dbz       <= 1'b1;
                            done      <= 1'b1;
                            state_reg <= FIN;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    shift_reg <= shift_next;
                    prem_reg  <= prem_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(DW - 1)) begin
                        // Last iteration: publish results so they coincide with done.
                        quotient  <= shift_next;
                        remainder <= prem_next[VW-1:0];
                        dbz       <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= FIN;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_DIVIDER_SELF_CHECK_EN
    logic [DW-1:0]    dividend_reg;
    logic [DW+VW-1:0] recon;
    logic             chk_bad;
    logic             chk_err_reg;

    // Keep the original dividend of the operation in flight for the check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dividend_reg <= '0;
        end else if (accept && (divisor != '0)) begin
            dividend_reg <= dividend;
        end
    end

    // Reconstruct the dividend from the published results.
    always_comb begin
        recon   = ({{VW{1'b0}}, quotient} * {{DW{1'b0}}, divisor_reg})
                + {{DW{1'b0}}, remainder};
        chk_bad = (recon != {{VW{1'b0}}, dividend_reg}) || (remainder >= divisor_reg);
    end

    // Sticky error flag evaluated during the FIN cycle of normal operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err_reg <= 1'b0;
        end else if ((state_reg == FIN) && !dbz && chk_bad) begin
            chk_err_reg <= 1'b1;
            $error("seq_divider self-check: dividend=%0d divisor=%0d quotient=%0d remainder=%0d",
                   dividend_reg, divisor_reg, quotient, remainder);
        end
    end

    assign chk_err = chk_err_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against
// plain integer division; one line printed per transaction.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;
    logic       chk_err;

    int checks   = 0;
    int failures = 0;

    int prev_q = 0;
    int prev_r = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full transaction: issue, verify timing and results against integer division.
    task automatic do_op(input int a, input int b);
        int exp_q, exp_r, exp_dbz, exp_lat, exp_busy;
        int cyc, nbusy;
        if (b == 0) begin
            exp_q = 255; exp_r = 0; exp_dbz = 1; exp_lat = 1; exp_busy = 0;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dbz = 0; exp_lat = 9; exp_busy = 8;
        end
        start    = 1'b1;
        dividend = a[7:0];
        divisor  = b[3:0];
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        if (b != 0) check("hold_q_on_accept", quotient, prev_q);
        cyc   = 1;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
        check("latency", cyc, exp_lat);
        check("busy_cycles", nbusy, exp_busy);
        check("busy_at_done", busy, 0);
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("dbz", dbz, exp_dbz);
        check("chk_err", chk_err, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("hold_q_idle", quotient, exp_q);
        prev_q = exp_q;
        prev_r = exp_r;
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b cycles=%0d", a, b, quotient, remainder, dbz, cyc);
    endtask

    initial begin
        int cyc;
        int a, b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", dbz, 0);
        check("rst_chk", chk_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations from the plan
        do_op(143, 11);
        do_op(7, 9);
        do_op(255, 1);
        do_op(225, 15);
        do_op(200, 0);
        do_op(143, 11);

        // start held high through RUN with changing operands, re-accepted in FIN
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(negedge clk);
        dividend = 8'd50; divisor = 4'd3;
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_first_latency", cyc, 9);
        check("b2b_first_q", quotient, 14);
        check("b2b_first_r", remainder, 2);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        check("b2b_done_low", done, 0);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_latency", cyc, 9);
        check("b2b_second_q", quotient, 16);
        check("b2b_second_r", remainder, 2);
        check("b2b_second_dbz", dbz, 0);
        $display("op 100 / 7 then 50 / 3 back-to-back -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);
        check("b2b_done_single", done, 0);
        prev_q = 16; prev_r = 2;

        // Reset in the middle of RUN aborts without a done pulse
        start = 1'b1; dividend = 8'd143; divisor = 4'd11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            check("abort_no_done", done, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dbz", dbz, 0);
        check("abort_chk", chk_err, 0);
        $display("op 143 / 11 aborted by reset");
        rst_n = 1'b1;
        prev_q = 0; prev_r = 0;
        @(negedge clk);
        do_op(60, 6);

        // Randomized operations, divisor zero included, random idle gaps
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            do_op(a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive sweep of non-zero divisors
        for (int bb = 1; bb < 16; bb++) begin
            for (int aa = 0; aa < 256; aa++) begin
                do_op(aa, bb);
            end
        end
        check("sweep_chk_err", chk_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
